fetch_unit: RTL and testbench



---
 rtl/fetch_unit_pkg.sv | 16 +
 rtl/fetch_queue.sv | 60 ++++++
 rtl/fetch_unit.sv | 94 +++++++++
 tb/tb_fetch_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch constants and PC helper
// Purpose : constants shared by the fetch front end and the core pipeline.
// Contents: XLEN, ILEN_BYTES, NOP_INSTR (addi x0,x0,0), RESET_PC, align_pc().
package fetch_unit_pkg;

    localparam int          XLEN       = 32;
    localparam int          ILEN_BYTES = 4;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;

    // Instruction fetch is word aligned; low address bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous prefetch FIFO of {pc, instr} entries
// Purpose : DEPTH-entry FIFO with synchronous flush and occupancy count.
// Ports   : i_clk, i_reset_n (async active-low)
//           i_flush              - empty the FIFO this edge (overrides push/pop)
//           i_push, i_push_data  - write one entry
//           i_pop                - drop the head entry (ignored when empty)
//           o_head               - head entry, meaningful only when o_count != 0
//           o_count              - current occupancy, 0..DEPTH
module fetch_queue #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;

    assign w_pop   = i_pop && (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
    end

    // The producer's credit check must make a push into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        !(i_push && !i_flush && (r_count == CNT_W'(DEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end with prefetch queue
// Purpose : owns the PC, issues one-cycle-latency imem reads, buffers
//           {pc, instr} in a prefetch queue and hands them to decode.
// Ports   : i_clk, i_reset_n (async active-low)
//           i_redirect, i_redirect_pc - flush and restart fetch at a new PC
//           o_imem_req, o_imem_addr   - imem read request / byte address
//           i_imem_data               - read data, the cycle after the request
//           o_valid, o_pc, o_instr    - queue head towards decode
//           i_ready                   - decode accepts the head this cycle
module fetch_unit #(
    parameter int          DEPTH     = 4,
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] RESET_PC  = fetch_unit_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = fetch_unit_pkg::NOP_INSTR
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_redirect,
    input  logic [31:0]       i_redirect_pc,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic [31:0]       i_imem_data,
    output logic              o_valid,
    output logic [31:0]       o_pc,
    output logic [31:0]       o_instr,
    input  logic              i_ready
);

    import fetch_unit_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]   r_fetch_pc;
    logic [XLEN-1:0]   r_inflight_pc;
    logic              r_inflight;
    logic              r_squash;

    logic [CNT_W-1:0]  w_count;
    logic [CNT_W:0]    w_credit;
    logic [2*XLEN-1:0] w_head;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_valid;

    // Occupancy plus the outstanding read must leave room for the response.
    assign w_credit = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_issue  = i_reset_n && !i_redirect && (w_credit < (CNT_W+1)'(DEPTH));

    assign w_valid  = (w_count != '0);
    // Redirect flushes the queue, so a same-cycle pop or push is discarded.
    assign w_pop    = w_valid && i_ready && !i_redirect;
    assign w_push   = r_inflight && !r_squash && !i_redirect;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight_pc <= '0;
            r_inflight    <= 1'b0;
            r_squash      <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            // Marks the response slot right after a redirect as stale.
            r_squash   <= i_redirect;
            if (w_issue) r_inflight_pc <= r_fetch_pc;
            if (i_redirect) begin
                r_fetch_pc <= align_pc(i_redirect_pc);
            end else if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(ILEN_BYTES);
            end
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (2*XLEN)
    ) u_queue (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_flush     (i_redirect),
        .i_push      (w_push),
        .i_push_data ({r_inflight_pc, i_imem_data}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign o_imem_req  = w_issue;
    assign o_imem_addr = r_fetch_pc[ADDR_W-1:0];
    assign o_valid     = w_valid;
    assign o_pc        = w_valid ? w_head[2*XLEN-1:XLEN] : '0;
    assign o_instr     = w_valid ? w_head[XLEN-1:0]      : NOP_INSTR;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] rpc = 32'h0;
    logic        ready = 1'b0;
    logic [31:0] imem_data = 32'h0;
    logic        req;
    logic [7:0]  addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .DEPTH     (DEPTH),
        .ADDR_W    (8),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_redirect    (redir),
        .i_redirect_pc (rpc),
        .o_imem_req    (req),
        .o_imem_addr   (addr),
        .i_imem_data   (imem_data),
        .o_valid       (valid),
        .o_pc          (pc),
        .o_instr       (instr),
        .i_ready       (ready)
    );

    // addi x1, x0, <byte address>: every word in the 256-byte space is distinct.
    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return {4'h0, a, 20'h00093};
    endfunction

    // Registered-output instruction memory.
    always @(posedge clk) if (req) imem_data <= mem_word(addr);

    // Reference model: queue contents, requests still waiting for data, next PC.
    logic [63:0] m_q[$];
    logic [31:0] m_pend[$];
    logic [31:0] m_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pend.delete();
        m_pc = 32'h0;
    endtask

    task automatic compare_model();
        bit          mv;
        bit          mreq;
        mv   = (m_q.size() != 0);
        mreq = rst_n && !redir && ((m_q.size() + m_pend.size()) < DEPTH);
        check("valid", {31'b0, valid}, {31'b0, mv});
        check("pc", pc, mv ? m_q[0][63:32] : 32'h0);
        check("instr", instr, mv ? m_q[0][31:0] : 32'h0000_0013);
        check("req", {31'b0, req}, {31'b0, mreq});
        check("addr", {24'b0, addr}, {24'b0, m_pc[7:0]});
    endtask

    task automatic model_step();
        bit issue;
        issue = !redir && ((m_q.size() + m_pend.size()) < DEPTH);
        if (redir) begin
            m_q.delete();
            m_pend.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            if (ready && m_q.size() != 0) void'(m_q.pop_front());
            if (m_pend.size() != 0) begin
                m_q.push_back({m_pend[0], mem_word(m_pend[0][7:0])});
                m_pend.delete();
            end
            if (issue) begin
                m_pend.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // Called just after a falling edge: apply inputs, then check outputs.
    task automatic drive(input bit r, input logic [31:0] p, input bit rd);
        redir = r;
        rpc   = p;
        ready = rd;
        #1;
        compare_model();
    endtask

    task automatic adv();
        model_step();
        @(negedge clk);
    endtask

    task automatic cyc(input bit r, input logic [31:0] p, input bit rd);
        drive(r, p, rd);
        adv();
    endtask

    initial begin
        int guard;
        model_reset();
        #1;
        compare_model();
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_req", {31'b0, req}, 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0000_0013);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Fill with decode stalled, then drain in order.
        for (int s = 0; s < 10; s++) begin
            drive(1'b0, 32'h0, 1'b0);
            if (s == 0) begin
                check("first_req", {31'b0, req}, 32'd1);
                check("first_addr", {24'b0, addr}, 32'h0);
            end
            if (s == 1) check("lat_valid_low", {31'b0, valid}, 32'd0);
            if (s == 2) begin
                check("lat_valid", {31'b0, valid}, 32'd1);
                check("lat_pc", pc, 32'h0);
                check("lat_instr", instr, 32'h0000_0093);
            end
            if (s == 9) begin
                check("full_req", {31'b0, req}, 32'd0);
                check("full_pc", pc, 32'h0);
            end
            adv();
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 32'h0, 1'b1);
            check("drain_valid", {31'b0, valid}, 32'd1);
            check("drain_pc", pc, 32'(4 * k));
            check("drain_instr", instr, {4'h0, 8'(4 * k), 20'h00093});
            adv();
        end

        // Asynchronous reset between clock edges.
        drive(1'b0, 32'h0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_valid", {31'b0, valid}, 32'd0);
        check("async_req", {31'b0, req}, 32'd0);
        compare_model();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b0);
        check("restart_addr", {24'b0, addr}, 32'h0);
        adv();

        // Reach 2 queued + 1 in flight, then redirect with a same-cycle pop.
        guard = 0;
        while (!(m_q.size() == 2 && m_pend.size() == 1) && guard < 12) begin
            cyc(1'b0, 32'h0, 1'b0);
            guard++;
        end
        check("setup_reached", {31'b0, (guard < 12)}, 32'd1);
        drive(1'b1, 32'h40, 1'b1);
        check("redir_req", {31'b0, req}, 32'd0);
        adv();
        drive(1'b0, 32'h0, 1'b1);
        check("r1_valid", {31'b0, valid}, 32'd0);
        check("r1_addr", {24'b0, addr}, 32'h40);
        adv();
        drive(1'b0, 32'h0, 1'b1);
        check("r2_valid", {31'b0, valid}, 32'd0);
        adv();
        drive(1'b0, 32'h0, 1'b1);
        check("r3_pc", pc, 32'h40);
        check("r3_instr", instr, 32'h0400_0093);
        adv();
        repeat (3) cyc(1'b0, 32'h0, 1'b1);

        // Back-to-back redirects: the later target wins.
        cyc(1'b1, 32'h40, 1'b1);
        cyc(1'b1, 32'h80, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        check("b2b_pc0", pc, 32'h80);
        adv();
        drive(1'b0, 32'h0, 1'b1);
        check("b2b_pc1", pc, 32'h84);
        adv();

        // Unaligned target at the top of the address space wraps to zero.
        cyc(1'b1, 32'hFFFF_FFFE, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        check("wrap_addr0", {24'b0, addr}, 32'hFC);
        adv();
        drive(1'b0, 32'h0, 1'b1);
        check("wrap_addr1", {24'b0, addr}, 32'h00);
        adv();
        drive(1'b0, 32'h0, 1'b1);
        check("wrap_pc0", pc, 32'hFFFF_FFFC);
        adv();
        drive(1'b0, 32'h0, 1'b1);
        check("wrap_pc1", pc, 32'h0);
        adv();

        // Random redirects and decode back-pressure.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 11) == 0), $urandom, ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
